// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte/FIFO geometry, header field
// positions and packet-count width. Used by the FIFO, FSM and synchronizer.
package router_pkg;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned DEPTH       = 16;
  localparam int unsigned AW          = 4;

  // Header byte layout: {len[7:2], addr[1:0]}
  localparam int unsigned HDR_LEN_MSB = 7;
  localparam int unsigned HDR_LEN_LSB = 2;
  localparam int unsigned HDR_ADDR_MSB = 1;
  localparam int unsigned HDR_ADDR_LSB = 0;
  localparam int unsigned HDR_LEN_W   = HDR_LEN_MSB - HDR_LEN_LSB + 1;

  localparam int unsigned PKT_CNT_W   = 7;

  // Remaining bytes after a header: payload length plus one parity byte
  function automatic logic [PKT_CNT_W-1:0] hdr_pkt_cnt(input logic [HDR_LEN_W-1:0] len);
    return PKT_CNT_W'(len) + PKT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/router_fifo.sv
// Per-port output FIFO of the 1x3 router. Stores {header_tag, byte} words,
// tracks the bytes left in the packet being read, and blanks data_out
// between packets.
module router_fifo
  import router_pkg::*;
#(
  parameter int unsigned WIDTH = router_pkg::WIDTH,
  parameter int unsigned DEPTH = router_pkg::DEPTH,
  parameter int unsigned AW    = router_pkg::AW
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             read_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  logic [WIDTH:0]           r_mem [DEPTH];
  logic [AW:0]              r_wr_ptr;
  logic [AW:0]              r_rd_ptr;
  logic [PKT_CNT_W-1:0]     r_pkt_cnt;
  logic [WIDTH-1:0]         r_data_out;

  logic                     w_flush;
  logic                     w_wr_acc;
  logic                     w_rd_acc;
  logic [WIDTH:0]           w_rd_word;
  logic [PKT_CNT_W-1:0]     w_pkt_cnt_nxt;
  logic [WIDTH-1:0]         w_data_out_nxt;

  assign w_flush   = reset | soft_reset;
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A write coinciding with a flush is discarded along with the buffered data
  assign w_wr_acc  = write_enb & ~full & ~w_flush;
  assign w_rd_acc  = read_enb & ~empty;
  assign w_rd_word = r_mem[r_rd_ptr[AW-1:0]];
  assign data_out  = r_data_out;

  // Storage write port; contents are never cleared
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Read/write pointers with extra wrap bit
  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Next packet count and output byte for the current cycle
  always_comb begin
    w_pkt_cnt_nxt  = r_pkt_cnt;
    w_data_out_nxt = r_data_out;
    if (w_rd_acc) begin
      w_data_out_nxt = w_rd_word[WIDTH-1:0];
      if (w_rd_word[WIDTH]) begin
        w_pkt_cnt_nxt = hdr_pkt_cnt(w_rd_word[HDR_LEN_MSB:HDR_LEN_LSB]);
      end else if (r_pkt_cnt != '0) begin
        w_pkt_cnt_nxt = r_pkt_cnt - 1'b1;
      end
    end else if (r_pkt_cnt == '0) begin
      // Between packets the output is blanked; parity thus shows for one cycle
      w_data_out_nxt = '0;
    end
  end

  // Packet count and registered read data
  always_ff @(posedge clock) begin
    if (w_flush) begin
      r_pkt_cnt  <= '0;
      r_data_out <= '0;
    end else begin
      r_pkt_cnt  <= w_pkt_cnt_nxt;
      r_data_out <= w_data_out_nxt;
    end
  end

endmodule
